// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared trace types and widths for the commit serializer
package mure_pkg;

  localparam int XLEN            = 64;
  localparam int CAUSE_LEN       = 8;
  localparam int ITYPE_LEN       = 3;
  localparam int PRIV_LEN        = 2;
  localparam int NR_COMMIT_PORTS = 2;

  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = ITYPE_LEN'(2);

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [ITYPE_LEN-1:0] itype;
    logic                 compressed;
    logic [PRIV_LEN-1:0]  priv;
  } uop_entry_s;

  typedef struct packed {
    uop_entry_s           uop;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
  } trace_entry_s;

  function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
    return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
  endfunction

endpackage

// File: rtl/commit_serializer_if.sv
// rtl/commit_serializer_if.sv - head-of-queue bus from the serializer to the trace FSM
interface commit_serializer_if;
  import mure_pkg::*;

  uop_entry_s           uop_entry;
  logic [CAUSE_LEN-1:0] cause;
  logic [XLEN-1:0]      tval;
  logic                 entry_valid;

  modport master (output uop_entry, output cause, output tval, output entry_valid);
  modport slave  (input  uop_entry, input  cause, input  tval, input  entry_valid);

endinterface

// File: rtl/fifo_2w1r.sv
// rtl/fifo_2w1r.sv - trace entry FIFO taking up to two writes and one read per cycle
module fifo_2w1r
  import mure_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   wr_cnt,
  input  trace_entry_s wr_data [2],
  input  logic         rd_en,
  output trace_entry_s rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);

  trace_entry_s  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  assign wr_ptr_nxt = wr_ptr + AW'(1);

  // DEPTH is a power of two, so pointer wrap is plain binary rollover
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      rd_ptr <= rd_ptr + AW'(rd_en);
      cnt    <= cnt + CW'(wr_cnt) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_cnt != 2'd0) mem[wr_ptr]     <= wr_data[0];
    if (wr_cnt == 2'd2) mem[wr_ptr_nxt] <= wr_data[1];
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;
  assign free    = CW'(DEPTH) - cnt;

endmodule

// File: rtl/commit_serializer.sv
// rtl/commit_serializer.sv - folds dual commit ports into a one-entry-per-cycle trace stream
module commit_serializer
  import mure_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int NR_PORTS = NR_COMMIT_PORTS,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  uop_entry_s           commit_i [NR_PORTS],
  input  logic [CAUSE_LEN-1:0] cause_i,
  input  logic [XLEN-1:0]      tval_i,
  input  logic                 clear_overflow_i,
  commit_serializer_if.master  trace,
  output logic [CW-1:0]        count_o,
  output logic                 overflow_o
);

  trace_entry_s  ent0, ent1;
  trace_entry_s  wr_data [2];
  trace_entry_s  head;
  logic          push0, push1, p0_trap, pop, accept;
  logic [1:0]    n_push, wr_cnt;
  logic [CW-1:0] count, free;

  always_comb begin
    p0_trap = is_trap(commit_i[0].itype);
    push0   = commit_i[0].valid || (commit_i[0].itype != '0);
    push1   = commit_i[1].valid && !p0_trap;

    ent0.uop   = commit_i[0];
    ent0.cause = p0_trap ? cause_i : '0;
    ent0.tval  = (commit_i[0].itype == ITYPE_EXC) ? tval_i : '0;

    // traps only ever retire on port 0; scrub any trap itype seen on port 1
    ent1.uop   = commit_i[1];
    ent1.cause = '0;
    ent1.tval  = '0;
    if (is_trap(commit_i[1].itype)) ent1.uop.itype = '0;

    wr_data[0] = push0 ? ent0 : ent1;
    wr_data[1] = ent1;
    n_push     = {push0 & push1, push0 ^ push1};

    // all-or-nothing: a cycle's pair is never split
    pop    = (count != '0);
    accept = CW'(n_push) <= (free + CW'(pop));
    wr_cnt = accept ? n_push : 2'd0;
  end

  fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .free    (free)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (!accept) begin
      overflow_o <= 1'b1;
    end else if (clear_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  assign trace.entry_valid = pop;
  assign trace.uop_entry   = pop ? head.uop   : '0;
  assign trace.cause       = pop ? head.cause : '0;
  assign trace.tval        = pop ? head.tval  : '0;
  assign count_o           = count;

endmodule

// File: tb/tb_commit_serializer.sv
// tb/tb_commit_serializer.sv - directed vector bench for commit_serializer
module tb_commit_serializer;
  import mure_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  uop_entry_s           commit [NR_COMMIT_PORTS];
  logic [CAUSE_LEN-1:0] cause;
  logic [XLEN-1:0]      tval;
  logic                 clear_overflow;
  logic [CW-1:0]        count;
  logic                 overflow;

  commit_serializer_if trace_bus ();

  commit_serializer #(.DEPTH(DEPTH), .NR_PORTS(NR_COMMIT_PORTS)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .commit_i         (commit),
    .cause_i          (cause),
    .tval_i           (tval),
    .clear_overflow_i (clear_overflow),
    .trace            (trace_bus),
    .count_o          (count),
    .overflow_o       (overflow)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic v0; logic [63:0] pc0; logic [2:0] it0; logic c0;
    logic v1; logic [63:0] pc1; logic [2:0] it1;
    logic [7:0] cause; logic [63:0] tval;
    logic e_ev; logic e_v; logic [63:0] e_pc; logic [2:0] e_it; logic e_c;
    logic [7:0] e_cause; logic [63:0] e_tval; logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [14];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [63:0] q_exp [$];
  logic [63:0] q_got [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [63:0] pc0, input logic [2:0] it0, input logic c0,
                       input logic v1, input logic [63:0] pc1, input logic [2:0] it1,
                       input logic [7:0] cs, input logic [63:0] tv);
    commit[0] = '{valid: v0, pc: pc0, itype: it0, compressed: c0, priv: 2'd3};
    commit[1] = '{valid: v1, pc: pc1, itype: it1, compressed: 1'b0, priv: 2'd3};
    cause = cs;
    tval  = tv;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, " ev"}, 64'(trace_bus.entry_valid), 0);
    chk({nm, " uop"}, 64'(trace_bus.uop_entry != '0), 0);
    chk({nm, " cause"}, 64'(trace_bus.cause), 0);
    chk({nm, " tval"}, trace_bus.tval, 0);
  endtask

  initial begin
    tbl[0]  = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           0, 0, 64'h0, 0, 0, 0, 64'h0, 0};
    tbl[1]  = '{1, 64'h8000_0000, 0, 1, 0, 64'h0, 0, 0, 64'h0,   1, 1, 64'h8000_0000, 0, 1, 0, 64'h0, 1};
    tbl[2]  = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           0, 0, 64'h0, 0, 0, 0, 64'h0, 0};
    tbl[3]  = '{1, 64'h100, 0, 0, 1, 64'h104, 0, 0, 64'h0,       1, 1, 64'h100, 0, 0, 0, 64'h0, 2};
    tbl[4]  = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           1, 1, 64'h104, 0, 0, 0, 64'h0, 1};
    tbl[5]  = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           0, 0, 64'h0, 0, 0, 0, 64'h0, 0};
    tbl[6]  = '{1, 64'h200, 1, 0, 1, 64'h204, 0, 2, 64'hDEAD,    1, 1, 64'h200, 1, 0, 2, 64'hDEAD, 1};
    tbl[7]  = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           0, 0, 64'h0, 0, 0, 0, 64'h0, 0};
    tbl[8]  = '{0, 64'h300, 2, 0, 0, 64'h0, 0, 7, 64'h55,        1, 0, 64'h300, 2, 0, 7, 64'h0, 1};
    tbl[9]  = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           0, 0, 64'h0, 0, 0, 0, 64'h0, 0};
    tbl[10] = '{1, 64'h400, 0, 0, 1, 64'h404, 1, 9, 64'h77,      1, 1, 64'h400, 0, 0, 0, 64'h0, 2};
    tbl[11] = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           1, 1, 64'h404, 0, 0, 0, 64'h0, 1};
    tbl[12] = '{0, 64'h0, 0, 0, 1, 64'h500, 4, 0, 64'h0,         1, 1, 64'h500, 4, 0, 0, 64'h0, 1};
    tbl[13] = '{0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 64'h0,           0, 0, 64'h0, 0, 0, 0, 64'h0, 0};

    idle();
    clear_overflow = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_empty("reset");
    chk("reset count", 64'(count), 0);
    chk("reset overflow", 64'(overflow), 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v0, tbl[i].pc0, tbl[i].it0, tbl[i].c0, tbl[i].v1, tbl[i].pc1, tbl[i].it1,
            tbl[i].cause, tbl[i].tval);
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("row%0d ev", i), 64'(trace_bus.entry_valid), 64'(tbl[i].e_ev));
      chk($sformatf("row%0d valid", i), 64'(trace_bus.uop_entry.valid), 64'(tbl[i].e_v));
      chk($sformatf("row%0d pc", i), trace_bus.uop_entry.pc, tbl[i].e_pc);
      chk($sformatf("row%0d itype", i), 64'(trace_bus.uop_entry.itype), 64'(tbl[i].e_it));
      chk($sformatf("row%0d compressed", i), 64'(trace_bus.uop_entry.compressed), 64'(tbl[i].e_c));
      chk($sformatf("row%0d cause", i), 64'(trace_bus.cause), 64'(tbl[i].e_cause));
      chk($sformatf("row%0d tval", i), trace_bus.tval, tbl[i].e_tval);
      chk($sformatf("row%0d count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("row%0d overflow", i), 64'(overflow), 0);
    end

    // burst of dual commits: count climbs 2..8, the pair arriving at count=8 is dropped
    begin
      logic [3:0] exp_cnt [9];
      exp_cnt = '{2, 3, 4, 5, 6, 7, 8, 7, 8};
      for (int k = 0; k < 9; k++) begin
        drive(1, 64'h1000 + 64'(16 * k), 0, 0, 1, 64'h1004 + 64'(16 * k), 0, 0, 0);
        if (k != 7) begin
          q_exp.push_back(64'h1000 + 64'(16 * k));
          q_exp.push_back(64'h1004 + 64'(16 * k));
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (trace_bus.entry_valid) q_got.push_back(trace_bus.uop_entry.pc);
        chk($sformatf("burst%0d count", k), 64'(count), 64'(exp_cnt[k]));
        chk($sformatf("burst%0d overflow", k), 64'(overflow), 64'(k >= 7));
      end
      idle();
      clear_overflow = 1'b1;
      for (int d = 0; d < 20; d++) begin
        @(posedge clk_i);
        @(negedge clk_i);
        if (d == 0) begin
          chk("overflow cleared", 64'(overflow), 0);
          clear_overflow = 1'b0;
        end
        if (!trace_bus.entry_valid) break;
        q_got.push_back(trace_bus.uop_entry.pc);
      end
      chk("burst drained count", 64'(count), 0);
      chk("burst entries seen", 64'(q_got.size()), 64'(q_exp.size()));
      for (int j = 0; j < q_exp.size() && j < q_got.size(); j++)
        chk($sformatf("burst order %0d", j), q_got[j], q_exp[j]);
    end

    // asynchronous reset with five entries in flight
    for (int k = 0; k < 4; k++) begin
      drive(1, 64'h2000 + 64'(16 * k), 0, 0, 1, 64'h2004 + 64'(16 * k), 0, 0, 0);
      @(posedge clk_i);
      @(negedge clk_i);
    end
    chk("pre-reset count", 64'(count), 5);
    idle();
    #2 rst_ni = 1'b0;
    #1;
    chk_empty("async reset");
    chk("async reset count", 64'(count), 0);
    chk("async reset overflow", 64'(overflow), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1, 64'h9000, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("post-reset ev", 64'(trace_bus.entry_valid), 1);
    chk("post-reset pc", trace_bus.uop_entry.pc, 64'h9000);
    chk("post-reset count", 64'(count), 1);
    idle();
    @(posedge clk_i);
    @(negedge clk_i);
    chk_empty("post-reset drain");
    chk("post-reset drain count", 64'(count), 0);
    chk("post-reset overflow", 64'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
